multiplier_pipelined_half_mac: RTL

//  Parametrised, pipelined signed/unsigned multiplier with optional accumulation.

---
 rtl/multiplier_pipelined_half_mac.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multiplier_pipelined_half_mac.sv
// rtl/multiplier_pipelined_half_mac.sv - pipelined full/dual-half multiplier with per-sample accumulate
// Input register, PIPE product stages, then accumulator; modes travel with each sample.
module multiplier_pipelined_half_mac #(
   parameter int A_W   = 18,
   parameter int B_W   = 18,
   parameter int PIPE  = 2,
   parameter int ACC_W = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [A_W-1:0]   A,
   input  logic [B_W-1:0]   B,
   input  logic             A_sign,
   input  logic             B_sign,
   input  logic             HALF_0,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   output logic [ACC_W-1:0] C
);

   localparam int HA  = A_W / 2;
   localparam int HB  = B_W / 2;
   localparam int HC  = ACC_W / 2;
   localparam int PW  = A_W + B_W;
   localparam int HPW = HA + HB;

   logic             in_v_q;
   logic [A_W-1:0]   a_q;
   logic [B_W-1:0]   b_q;
   logic             as_q;
   logic             bs_q;
   logic             half_q;
   logic             accum_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_v_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         as_q    <= 1'b0;
         bs_q    <= 1'b0;
         half_q  <= 1'b0;
         accum_q <= 1'b0;
      end else begin
         in_v_q <= in_valid;
         if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            as_q    <= A_sign;
            bs_q    <= B_sign;
            half_q  <= HALF_0;
            accum_q <= acc_en & ~acc_clr;
         end
      end
   end

   // Operands are extended to the product width so the low bits of an unsigned
   // multiply equal the exact signed/unsigned product.
   logic [PW-1:0]    fa_w;
   logic [PW-1:0]    fb_w;
   logic [PW-1:0]    full_raw;
   logic [HPW-1:0]   la_w;
   logic [HPW-1:0]   lb_w;
   logic [HPW-1:0]   lo_raw;
   logic [HPW-1:0]   ha_w;
   logic [HPW-1:0]   hb_w;
   logic [HPW-1:0]   hi_raw;
   logic [ACC_W-1:0] full_p;
   logic [HC-1:0]    lo_p;
   logic [HC-1:0]    hi_p;
   logic [ACC_W-1:0] prod;
   logic             prod_signed;

   always_comb begin
      prod_signed = as_q | bs_q;

      fa_w     = {{(PW-A_W){a_q[A_W-1] & as_q}}, a_q};
      fb_w     = {{(PW-B_W){b_q[B_W-1] & bs_q}}, b_q};
      full_raw = fa_w * fb_w;

      la_w   = {{(HPW-HA){a_q[HA-1] & as_q}}, a_q[HA-1:0]};
      lb_w   = {{(HPW-HB){b_q[HB-1] & bs_q}}, b_q[HB-1:0]};
      lo_raw = la_w * lb_w;

      ha_w   = {{(HPW-HA){a_q[A_W-1] & as_q}}, a_q[A_W-1:HA]};
      hb_w   = {{(HPW-HB){b_q[B_W-1] & bs_q}}, b_q[B_W-1:HB]};
      hi_raw = ha_w * hb_w;

      full_p           = {ACC_W{prod_signed & full_raw[PW-1]}};
      full_p[PW-1:0]   = full_raw;
      lo_p             = {HC{prod_signed & lo_raw[HPW-1]}};
      lo_p[HPW-1:0]    = lo_raw;
      hi_p             = {HC{prod_signed & hi_raw[HPW-1]}};
      hi_p[HPW-1:0]    = hi_raw;

      prod = half_q ? {hi_p, lo_p} : full_p;
   end

   logic [PIPE-1:0]  st_v;
   logic [PIPE-1:0]  st_half;
   logic [PIPE-1:0]  st_accum;
   logic [ACC_W-1:0] st_p [PIPE];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_v     <= '0;
         st_half  <= '0;
         st_accum <= '0;
         for (int k = 0; k < PIPE; k++) begin
            st_p[k] <= '0;
         end
      end else begin
         st_v[0]     <= in_v_q;
         st_half[0]  <= half_q;
         st_accum[0] <= accum_q;
         st_p[0]     <= prod;
         for (int k = 1; k < PIPE; k++) begin
            st_v[k]     <= st_v[k-1];
            st_half[k]  <= st_half[k-1];
            st_accum[k] <= st_accum[k-1];
            st_p[k]     <= st_p[k-1];
         end
      end
   end

   logic [ACC_W-1:0] acc_q;
   logic             ov_q;
   logic [ACC_W-1:0] p_last;
   logic [ACC_W-1:0] full_sum;
   logic [HC-1:0]    lo_sum;
   logic [HC-1:0]    hi_sum;
   logic [ACC_W-1:0] acc_next;

   // Half-mode sums are per lane, so the lo carry never reaches the hi lane.
   always_comb begin
      p_last   = st_p[PIPE-1];
      full_sum = acc_q + p_last;
      lo_sum   = acc_q[HC-1:0] + p_last[HC-1:0];
      hi_sum   = acc_q[ACC_W-1:HC] + p_last[ACC_W-1:HC];
      acc_next = p_last;
      if (st_accum[PIPE-1]) begin
         acc_next = st_half[PIPE-1] ? {hi_sum, lo_sum} : full_sum;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         ov_q  <= 1'b0;
      end else begin
         ov_q <= st_v[PIPE-1];
         if (st_v[PIPE-1]) begin
            acc_q <= acc_next;
         end
      end
   end

   assign C         = acc_q;
   assign out_valid = ov_q;

endmodule
